// File: rtl/ysyx_24080006_mdu.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply, restoring divide.
// Optional YSYX_24080006_MDU_REM_CACHE_EN keeps the last quotient/remainder pair for repeated divides.
module ysyx_24080006_mdu #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);
  localparam int ITER_M = WIDTH / MUL_STEP;
  localparam int CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_M = CW'(ITER_M - 1);
  localparam logic [CW-1:0] LAST_D = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state, state_n;

  logic [2:0]         op_r;
  logic               neg_res, neg_r;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand, acc, pp_sum, prod;
  logic [WIDTH-1:0]   mplier, quo, rem, dvs, quo_s, rem_s, fix_res;
  logic [WIDTH:0]     shifted, diff;

  logic             is_div, signed_a, signed_b, sign_a, sign_b;
  logic             div_zero, div_ovf, special, cache_hit;
  logic [WIDTH-1:0] mag_a, mag_b, min_val, special_res, hit_res, early_res;

  assign min_val  = {1'b1, {(WIDTH-1){1'b0}}};
  assign is_div   = op[2];
  assign signed_a = !(op[0] && (op[1] || op[2]));
  assign signed_b = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
  assign sign_a   = signed_a && a[WIDTH-1];
  assign sign_b   = signed_b && b[WIDTH-1];
  assign mag_a    = sign_a ? -a : a;
  assign mag_b    = sign_b ? -b : b;

  // Divide-by-zero and signed overflow bypass the iterative datapath entirely
  assign div_zero    = (b == '0);
  assign div_ovf     = !op[0] && (a == min_val) && (b == '1);
  assign special     = is_div && (div_zero || div_ovf);
  assign special_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : min_val);
  assign early_res   = special ? special_res : hit_res;

`ifdef YSYX_24080006_MDU_REM_CACHE_EN
  logic             cache_valid, cache_signed;
  logic [WIDTH-1:0] cache_a, cache_b, cache_q, cache_r, a_r, b_r;

  assign cache_hit = is_div && cache_valid && (a == cache_a) && (b == cache_b)
                     && (cache_signed == !op[0]);
  assign hit_res   = op[1] ? cache_r : cache_q;

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      cache_valid <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_r <= a;
      b_r <= b;
      if (!is_div) cache_valid <= 1'b0;
    end else if (state == FIX && op_r[2]) begin
      cache_valid  <= 1'b1;
      cache_signed <= !op_r[0];
      cache_a      <= a_r;
      cache_b      <= b_r;
      cache_q      <= quo_s;
      cache_r      <= rem_s;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_res   = '0;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    pp_sum = '0;
    for (int j = 0; j < MUL_STEP; j++)
      if (mplier[j]) pp_sum = pp_sum + (mcand << j);
  end

  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};

  // Signs were stripped on entry and are restored here
  assign prod  = neg_res ? -acc : acc;
  assign quo_s = neg_res ? -quo : quo;
  assign rem_s = neg_r ? -rem : rem;

  always_comb begin
    fix_res = rem_s;
    case (op_r)
      3'd0:              fix_res = prod[WIDTH-1:0];
      3'd1, 3'd2, 3'd3:  fix_res = prod[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:        fix_res = quo_s;
      default:           fix_res = rem_s;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (!is_div)                  state_n = MUL;
          else if (special || cache_hit) state_n = DONE;
          else                          state_n = DIV;
        end
        MUL:     if (cnt == LAST_M) state_n = FIX;
        DIV:     if (cnt == LAST_D) state_n = FIX;
        FIX:     state_n = DONE;
        DONE:    if (out_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_r    <= op;
          cnt     <= '0;
          neg_res <= sign_a ^ sign_b;
          neg_r   <= sign_a;
          mcand   <= {{WIDTH{1'b0}}, mag_a};
          mplier  <= mag_b;
          acc     <= '0;
          quo     <= mag_a;
          rem     <= '0;
          dvs     <= mag_b;
          if (special || cache_hit) begin
            out_result <= early_res;
            out_valid  <= 1'b1;
          end
        end
        MUL: begin
          acc    <= acc + pp_sum;
          mcand  <= mcand << MUL_STEP;
          mplier <= mplier >> MUL_STEP;
          cnt    <= cnt + 1'b1;
        end
        // Restoring step: keep the trial difference only when it did not go negative
        DIV: begin
          rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], !diff[WIDTH]};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          out_result <= fix_res;
          out_valid  <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_24080006_mdu.sv
// Self-checking bench for ysyx_24080006_mdu: directed spec cases plus randomized ops against an arithmetic model.
// Latency expectations follow YSYX_24080006_MDU_REM_CACHE_EN when it is defined for the build.
module tb_ysyx_24080006_mdu;
`ifdef YSYX_24080006_MDU_REM_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n, flush, in_valid, in_valid4, out_ready, out_ready4;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        in_ready, out_valid, busy, in_ready4, out_valid4, busy4;
  logic [31:0] out_result, out_result4;

  int n_cmp = 0;
  int n_err = 0;

  bit          c_valid = 1'b0;
  bit          c_signed;
  logic [31:0] c_a, c_b;

  always #5 clock = ~clock;

  ysyx_24080006_mdu #(.WIDTH(32), .MUL_STEP(1)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy)
  );

  ysyx_24080006_mdu #(.WIDTH(32), .MUL_STEP(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid4), .in_ready(in_ready4),
    .op(op), .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_result(out_result4), .busy(busy4)
  );

  // Reference arithmetic on 64-bit integers, independent of the iterative datapath
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, ux, uy, p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (f)
      3'd0: begin p = sx * sy; return p[31:0];  end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      default: begin
        if (y == 32'd0) return f[1] ? x : 32'hFFFFFFFF;
        if (!f[0]) begin
          if (x == 32'h80000000 && y == 32'hFFFFFFFF) return f[1] ? 32'd0 : 32'h80000000;
          p = f[1] ? (sx % sy) : (sx / sy);
        end else begin
          p = f[1] ? (ux % uy) : (ux / uy);
        end
        return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    return f[2] && (y == 32'd0 || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF));
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (!f[2]) return 33;
    if (is_special(f, x, y)) return 1;
    if (CACHE_ON && c_valid && c_a == x && c_b == y && c_signed == !f[0]) return 1;
    return 33;
  endfunction

  task automatic model_note(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (!f[2]) begin
      c_valid = 1'b0;
    end else if (!is_special(f, x, y)) begin
      c_valid  = 1'b1;
      c_signed = !f[0];
      c_a      = x;
      c_b      = y;
    end
  endtask

  // Drives one request and returns result plus edges from accept to first out_valid (-1 on timeout)
  task automatic do_op(input bit use4, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int edges);
    op = f;
    a  = x;
    b  = y;
    if (use4) in_valid4 = 1'b1;
    else      in_valid  = 1'b1;
    @(posedge clock); #1;
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
    edges = -1;
    res   = 32'hxxxxxxxx;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock); #1;
      if (use4 ? out_valid4 : out_valid) begin
        edges = i;
        res   = use4 ? out_result4 : out_result;
        break;
      end
    end
    if (edges > 0) begin
      if (use4) out_ready4 = 1'b1;
      else      out_ready  = 1'b1;
      @(posedge clock); #1;
      out_ready  = 1'b0;
      out_ready4 = 1'b0;
    end
    if (!use4) model_note(f, x, y);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_result !== 32'd0) begin n_err++; $display("[TB] FAIL reset_out_result: got %h expected 0", out_result); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    reset_n = 1'b1;
    c_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_mul_directed();
    logic [2:0]  t_op [4];
    logic [31:0] t_a [4], t_b [4], t_exp [4];
    logic [31:0] res;
    int          edges;
    t_op  = '{3'd0, 3'd1, 3'd3, 3'd2};
    t_a   = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    t_b   = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    t_exp = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, t_op[i], t_a[i], t_b[i], res, edges);
      n_cmp++; if (res !== t_exp[i]) begin n_err++; $display("[TB] FAIL mul_result[%0d]: got %h expected %h", i, res, t_exp[i]); end
      n_cmp++; if (edges != 33) begin n_err++; $display("[TB] FAIL mul_latency[%0d]: got %0d expected 33", i, edges); end
    end
  endtask

  task automatic test_div_directed();
    logic [2:0]  t_op [4];
    logic [31:0] t_a [4], t_b [4], t_exp [4];
    logic [31:0] res;
    int          edges, lat;
    t_op  = '{3'd4, 3'd6, 3'd5, 3'd7};
    t_a   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    t_b   = '{32'd2, 32'd2, 32'd7, 32'd7};
    t_exp = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      lat = exp_latency(t_op[i], t_a[i], t_b[i]);
      do_op(1'b0, t_op[i], t_a[i], t_b[i], res, edges);
      n_cmp++; if (res !== t_exp[i]) begin n_err++; $display("[TB] FAIL div_result[%0d]: got %h expected %h", i, res, t_exp[i]); end
      n_cmp++; if (edges != lat) begin n_err++; $display("[TB] FAIL div_latency[%0d]: got %0d expected %0d", i, edges, lat); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  t_op [4];
    logic [31:0] t_a [4], t_b [4], t_exp [4];
    logic [31:0] res;
    int          edges;
    t_op  = '{3'd5, 3'd6, 3'd4, 3'd6};
    t_a   = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    t_b   = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    t_exp = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, t_op[i], t_a[i], t_b[i], res, edges);
      n_cmp++; if (res !== t_exp[i]) begin n_err++; $display("[TB] FAIL special_result[%0d]: got %h expected %h", i, res, t_exp[i]); end
      n_cmp++; if (edges != 1) begin n_err++; $display("[TB] FAIL special_latency[%0d]: got %0d expected 1", i, edges); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] x, y, px, py, exp_res, res;
    int          lat, edges, mode;
    px = 32'd1000;
    py = 32'd7;
    for (int i = 0; i < 40; i++) begin
      f    = 3'($urandom_range(0, 7));
      x    = $urandom;
      y    = $urandom;
      mode = $urandom_range(0, 9);
      case (mode)
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: begin x = px; y = py; end
        4: begin x = px; y = py; f = {1'b1, f[1:0]}; end
        default: ;
      endcase
      exp_res = ref_model(f, x, y);
      lat     = exp_latency(f, x, y);
      do_op(1'b0, f, x, y, res, edges);
      n_cmp++; if (res !== exp_res) begin n_err++; $display("[TB] FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h expected %h", i, f, x, y, res, exp_res); end
      n_cmp++; if (edges != lat) begin n_err++; $display("[TB] FAIL rand_latency[%0d] op=%0d: got %0d expected %0d", i, f, edges, lat); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rand_ready_after[%0d]: got %b expected 1", i, in_ready); end
      px = x;
      py = y;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] x, y, exp_res;
    int          edges;
    x = $urandom;
    y = $urandom;
    exp_res = ref_model(3'd0, x, y);
    op = 3'd0; a = x; b = y; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    edges = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock); #1;
      if (out_valid) begin edges = i; break; end
    end
    n_cmp++; if (edges != 33) begin n_err++; $display("[TB] FAIL bp_latency: got %0d expected 33", edges); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp_valid_held[%0d]: got %b expected 1", k, out_valid); end
      n_cmp++; if (out_result !== exp_res) begin n_err++; $display("[TB] FAIL bp_result_stable[%0d]: got %h expected %h", k, out_result, exp_res); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", k, in_ready); end
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bp_valid_drop: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bp_ready_back: got %b expected 1", in_ready); end
    model_note(3'd0, x, y);
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int          edges;
    bit          seen;
    op = 3'd4; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    flush = 1'b1;
    @(posedge clock); #1;
    flush   = 1'b0;
    c_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL flush_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | out_valid;
      @(posedge clock); #1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("[TB] FAIL flush_no_result: got %b expected 0", seen); end
    op = 3'd0; a = 32'd9; b = 32'd9; in_valid = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL flush_blocks_accept: got busy=%b expected 0", busy); end
    do_op(1'b0, 3'd0, 32'd3, 32'd4, res, edges);
    n_cmp++; if (res !== 32'd12) begin n_err++; $display("[TB] FAIL flush_next_mul: got %h expected 0000000c", res); end
    n_cmp++; if (edges != 33) begin n_err++; $display("[TB] FAIL flush_next_latency: got %0d expected 33", edges); end
  endtask

  task automatic test_reset_midop();
    bit seen;
    op = 3'd5; a = 32'd12345; b = 32'd11; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    c_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL midreset_in_ready: got %b expected 1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | out_valid;
      @(posedge clock); #1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_no_result: got %b expected 0", seen); end
  endtask

  task automatic test_cache();
    logic [31:0] res;
    int          edges, hit_lat;
    hit_lat = CACHE_ON ? 1 : 33;
    do_op(1'b0, 3'd0, 32'd2, 32'd2, res, edges);
    do_op(1'b0, 3'd4, 32'd100, 32'd7, res, edges);
    n_cmp++; if (res !== 32'd14) begin n_err++; $display("[TB] FAIL cache_div: got %h expected 0000000e", res); end
    n_cmp++; if (edges != 33) begin n_err++; $display("[TB] FAIL cache_div_latency: got %0d expected 33", edges); end
    do_op(1'b0, 3'd6, 32'd100, 32'd7, res, edges);
    n_cmp++; if (res !== 32'd2) begin n_err++; $display("[TB] FAIL cache_rem: got %h expected 00000002", res); end
    n_cmp++; if (edges != hit_lat) begin n_err++; $display("[TB] FAIL cache_rem_latency: got %0d expected %0d", edges, hit_lat); end
    flush = 1'b1;
    @(posedge clock); #1;
    flush   = 1'b0;
    c_valid = 1'b0;
    do_op(1'b0, 3'd6, 32'd100, 32'd7, res, edges);
    n_cmp++; if (res !== 32'd2) begin n_err++; $display("[TB] FAIL cache_flush_rem: got %h expected 00000002", res); end
    n_cmp++; if (edges != 33) begin n_err++; $display("[TB] FAIL cache_flush_latency: got %0d expected 33", edges); end
  endtask

  task automatic test_mul_step4();
    logic [2:0]  f;
    logic [31:0] x, y, exp_res, res;
    int          edges;
    do_op(1'b1, 3'd0, 32'd7, 32'hFFFFFFFD, res, edges);
    n_cmp++; if (res !== 32'hFFFFFFEB) begin n_err++; $display("[TB] FAIL step4_mul: got %h expected ffffffeb", res); end
    n_cmp++; if (edges != 9) begin n_err++; $display("[TB] FAIL step4_latency: got %0d expected 9", edges); end
    for (int i = 0; i < 8; i++) begin
      f = 3'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      exp_res = ref_model(f, x, y);
      do_op(1'b1, f, x, y, res, edges);
      n_cmp++; if (res !== exp_res) begin n_err++; $display("[TB] FAIL step4_rand[%0d] op=%0d a=%h b=%h: got %h expected %h", i, f, x, y, res, exp_res); end
      n_cmp++; if (edges != 9) begin n_err++; $display("[TB] FAIL step4_rand_latency[%0d]: got %0d expected 9", i, edges); end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_valid4  = 1'b0;
    out_ready  = 1'b0;
    out_ready4 = 1'b0;
    op         = 3'd0;
    a          = 32'd0;
    b          = 32'd0;
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_special();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_cache();
    test_mul_step4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
